// File: rtl/wishbone_pkg.sv
// wishbone_pkg: shared Wishbone B4 definitions.
//   - Cycle-type (CTI) encodings used by masters and responders.
//   - One-hot state encoding for the register responder FSM.
package wishbone_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_WAIT  = 4'b0010,
    ST_ACK   = 4'b0100,
    ST_BURST = 4'b1000
  } slave_state_t;

endpackage

// File: rtl/register_bank.sv
// register_bank: DEPTH x DATA_WIDTH register array.
//   clk_i, rst_i    clock, asynchronous active-high reset (clears all entries)
//   bus_*           bus write port, byte lanes per bus_sel_i (all-zero = all lanes);
//                   wins over the fabric port when both target the same entry
//   hw_*            fabric write port, whole-word
//   rd_index_i      read index; rd_data_o is the value the entry will hold after
//                   this edge, so a same-edge write is bypassed to the reader
//   regs_o          flat image, entry k at [k*DATA_WIDTH +: DATA_WIDTH]
module register_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_BYTES = 1,
  parameter int DEPTH      = 16,
  parameter int INDEX_N    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        bus_we_i,
  input  logic [INDEX_N-1:0]          bus_index_i,
  input  logic [DATA_BYTES-1:0]       bus_sel_i,
  input  logic [DATA_WIDTH-1:0]       bus_data_i,
  input  logic                        hw_we_i,
  input  logic [INDEX_N-1:0]          hw_index_i,
  input  logic [DATA_WIDTH-1:0]       hw_data_i,
  input  logic [INDEX_N-1:0]          rd_index_i,
  output logic [DATA_WIDTH-1:0]       rd_data_o,
  output logic [DEPTH*DATA_WIDTH-1:0] regs_o
);

  localparam int LANE = DATA_WIDTH / DATA_BYTES;

  logic [DATA_BYTES-1:0] sel_eff;
  logic [DATA_WIDTH-1:0] bus_mask;
  logic [DATA_WIDTH-1:0] nxt [DEPTH];

  assign sel_eff = (bus_sel_i == '0) ? '1 : bus_sel_i;

  always_comb begin
    bus_mask = '0;
    for (int b = 0; b < DATA_BYTES; b++) begin
      bus_mask[b*LANE +: LANE] = {LANE{sel_eff[b]}};
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;
    logic                  bus_hit;
    logic                  hw_hit;

    assign bus_hit = bus_we_i && (bus_index_i == INDEX_N'(k));
    assign hw_hit  = hw_we_i && (hw_index_i == INDEX_N'(k));
    assign nxt[k]  = bus_hit ? ((q & ~bus_mask) | (bus_data_i & bus_mask)) :
                     hw_hit  ? hw_data_i : q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) q <= '0;
      else       q <= nxt[k];
    end

    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = q;
  end

  assign rd_data_o = nxt[rd_index_i];

endmodule

// File: rtl/wishbone_slave_regs.sv
// wishbone_slave_regs: Wishbone B4 responder for DEPTH registers at BASE_ADDRESS.
//   clk_i, rst_i         clock, asynchronous active-high reset
//   adr_i..cti_i, ack_o  Wishbone target port (classic + incrementing bursts)
//   regs_o               flat register image for fabric logic
//   wr_pulse_o           one-cycle pulse after each bus write beat
//   wr_index_o           index of the last bus write
//   hw_we_i/index/data   fabric write port (loses to a same-index bus write)
//
// Handshake: a beat completes on every clock edge where ack_o is high.
// ack_o is a registered flag gated by cyc_i, so a master dropping cyc_i
// cancels the beat in the same cycle; writes only happen on completed beats.
// dat_o is registered and valid throughout each ack cycle.
module wishbone_slave_regs
  import wishbone_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       DATA_WIDTH    = 8,
  parameter int                       DATA_BYTES    = 1,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0,
  parameter int                       DEPTH         = 16,
  parameter int                       WAIT_STATES   = 1,
  parameter int                       REQUIRE_STB   = 0,
  localparam int                      INDEX_N       = $clog2(DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [ADDRESS_WIDTH-1:0]    adr_i,
  input  logic [DATA_WIDTH-1:0]       dat_i,
  output logic [DATA_WIDTH-1:0]       dat_o,
  input  logic                        we_i,
  input  logic [DATA_BYTES-1:0]       sel_i,
  input  logic                        stb_i,
  input  logic                        cyc_i,
  input  logic [2:0]                  cti_i,
  output logic                        ack_o,
  output logic [DEPTH*DATA_WIDTH-1:0] regs_o,
  output logic                        wr_pulse_o,
  output logic [INDEX_N-1:0]          wr_index_o,
  input  logic                        hw_we_i,
  input  logic [INDEX_N-1:0]          hw_index_i,
  input  logic [DATA_WIDTH-1:0]       hw_data_i
);

  // WAIT holds WAIT_STATES cycles, so the counter starts one below.
  localparam int                   WS_LOAD   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]           WAIT_LOAD = WS_LOAD[3:0];
  localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH+1)'(DEPTH);

  slave_state_t          state;
  logic [INDEX_N-1:0]    ptr;
  logic [3:0]            wait_cnt;
  logic                  ack_reg;

  logic [ADDRESS_WIDTH:0] offset;
  logic                   request;
  logic [INDEX_N-1:0]     index;
  logic [INDEX_N-1:0]     rd_index;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   bus_we;

  // Extra top bit catches addresses below BASE_ADDRESS (they wrap huge).
  assign offset  = {1'b0, adr_i} - {1'b0, BASE_ADDRESS};
  assign index   = offset[INDEX_N-1:0];
  assign request = cyc_i && (stb_i || (REQUIRE_STB == 0)) && (offset < DEPTH_W);

  assign ack_o  = ack_reg & cyc_i;
  assign bus_we = ack_o & we_i;

  // Read index matches the pointer of the beat being entered at this edge.
  always_comb begin
    rd_index = ptr + INDEX_N'(1);
    case (state)
      ST_IDLE: rd_index = index;
      ST_WAIT: rd_index = ptr;
      default: rd_index = ptr + INDEX_N'(1);
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      wait_cnt   <= '0;
      ack_reg    <= 1'b0;
      dat_o      <= '0;
      wr_pulse_o <= 1'b0;
      wr_index_o <= '0;
    end else begin
      wr_pulse_o <= bus_we;
      if (bus_we) wr_index_o <= ptr;
      ack_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (request) begin
            ptr <= index;
            if (WAIT_STATES == 0) begin
              state   <= ST_ACK;
              ack_reg <= 1'b1;
              dat_o   <= rd_data;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!request) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state   <= ST_ACK;
            ack_reg <= 1'b1;
            dat_o   <= rd_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK, ST_BURST: begin
          if (cyc_i && ((state == ST_ACK && cti_i == CTI_INCR) ||
                        (state == ST_BURST && cti_i != CTI_END))) begin
            state   <= ST_BURST;
            ptr     <= ptr + INDEX_N'(1);
            ack_reg <= 1'b1;
            dat_o   <= rd_data;  // prefetch of ptr+1, bypassing this beat's write
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  register_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DATA_BYTES(DATA_BYTES),
    .DEPTH     (DEPTH),
    .INDEX_N   (INDEX_N)
  ) u_bank (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus_we_i   (bus_we),
    .bus_index_i(ptr),
    .bus_sel_i  (sel_i),
    .bus_data_i (dat_i),
    .hw_we_i    (hw_we_i),
    .hw_index_i (hw_index_i),
    .hw_data_i  (hw_data_i),
    .rd_index_i (rd_index),
    .rd_data_o  (rd_data),
    .regs_o     (regs_o)
  );

endmodule

// File: tb/tb_wishbone_slave_regs.sv
// tb_wishbone_slave_regs: directed bench for wishbone_slave_regs with default
// parameters (16 x 8-bit registers at 0x0000, one wait state).
module tb_wishbone_slave_regs;
  import wishbone_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int DB = 1;
  localparam int DEPTH = 16;
  localparam int IDX = 4;
  localparam int WS = 1;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [AW-1:0]       adr_i;
  logic [DW-1:0]       dat_i;
  logic [DW-1:0]       dat_o;
  logic                we_i;
  logic [DB-1:0]       sel_i;
  logic                stb_i;
  logic                cyc_i;
  logic [2:0]          cti_i;
  logic                ack_o;
  logic [DEPTH*DW-1:0] regs_o;
  logic                wr_pulse_o;
  logic [IDX-1:0]      wr_index_o;
  logic                hw_we_i;
  logic [IDX-1:0]      hw_index_i;
  logic [DW-1:0]       hw_data_i;

  wishbone_slave_regs #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(DB), .BASE_ADDRESS(16'h0000),
    .DEPTH(DEPTH), .WAIT_STATES(WS), .REQUIRE_STB(0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .cti_i(cti_i),
    .ack_o(ack_o), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .wr_index_o(wr_index_o),
    .hw_we_i(hw_we_i), .hw_index_i(hw_index_i), .hw_data_i(hw_data_i)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DEPTH*DW-1:0] image();
    logic [DEPTH*DW-1:0] r;
    for (int k = 0; k < DEPTH; k++) r[k*DW +: DW] = model[k];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [AW-1:0]  adr;
    logic           we;
    logic [DW-1:0]  dat;
    logic [DB-1:0]  sel;
    logic           exp_ack;
    logic [DW-1:0]  exp_rd;
    logic           hw_we;
    logic [IDX-1:0] hw_idx;
    logic [DW-1:0]  hw_dat;
  } vec_t;

  task automatic bus_idle();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = CTI_CLASSIC; hw_we_i = 1'b0;
  endtask

  task automatic classic(input vec_t v);
    int n;
    bit got;
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = v.adr; we_i = v.we; dat_i = v.dat;
    sel_i = v.sel; cti_i = CTI_CLASSIC;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk_i);
      n++;
      if (ack_o) got = 1'b1;
    end
    check("ack_seen", 128'(got), 128'(v.exp_ack));
    if (got) begin
      check("ack_latency", 128'(n), 128'(WS + 2));
      if (!v.we) check("read_data", 128'(dat_o), 128'(v.exp_rd));
      if (v.hw_we) begin
        hw_we_i = 1'b1; hw_index_i = v.hw_idx; hw_data_i = v.hw_dat;
        model[v.hw_idx] = v.hw_dat;
      end
      if (v.we) model[v.adr[IDX-1:0]] = v.dat;
      @(posedge clk_i); #1;
      bus_idle();
      @(negedge clk_i);
      check("ack_drop", 128'(ack_o), 128'(0));
      check("wr_pulse", 128'(wr_pulse_o), 128'(v.we));
      if (v.we) check("wr_index", 128'(wr_index_o), 128'(v.adr[IDX-1:0]));
      check("regs_image", 128'(regs_o), 128'(image()));
      @(negedge clk_i);
      check("wr_pulse_end", 128'(wr_pulse_o), 128'(0));
    end else begin
      @(posedge clk_i); #1;
      bus_idle();
      @(negedge clk_i);
      check("regs_unchanged", 128'(regs_o), 128'(image()));
    end
  endtask

  task automatic wait_ack(output bit got);
    int n;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk_i);
      n++;
      if (ack_o) got = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs [18];
  vec_t v;
  bit got;

  initial begin
    vecs[0]  = '{16'h0003, 1'b1, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[1]  = '{16'h0003, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 4'h0, 8'h00};
    vecs[2]  = '{16'h000F, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[3]  = '{16'h000F, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 4'h0, 8'h00};
    vecs[4]  = '{16'h0000, 1'b1, 8'h11, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[5]  = '{16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 4'h0, 8'h00};
    vecs[6]  = '{16'h0005, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[7]  = '{16'h0010, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[8]  = '{16'h0010, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[9]  = '{16'h0004, 1'b1, 8'h77, 1'b1, 1'b1, 8'h00, 1'b1, 4'h4, 8'hEE};
    vecs[10] = '{16'h0004, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 1'b0, 4'h0, 8'h00};
    vecs[11] = '{16'h0006, 1'b1, 8'h66, 1'b1, 1'b1, 8'h00, 1'b1, 4'h7, 8'h99};
    vecs[12] = '{16'h0007, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0, 4'h0, 8'h00};
    vecs[13] = '{16'h000A, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[14] = '{16'h000E, 1'b1, 8'h0E, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[15] = '{16'h000F, 1'b1, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[16] = '{16'h0000, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00};
    vecs[17] = '{16'h0001, 1'b1, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00};

    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    rst_i = 1'b1;
    adr_i = '0; dat_i = '0; sel_i = '0; hw_index_i = '0; hw_data_i = '0;
    bus_idle();
    @(negedge clk_i); @(negedge clk_i);
    check("rst_ack", 128'(ack_o), 128'(0));
    check("rst_dat", 128'(dat_o), 128'(0));
    check("rst_regs", 128'(regs_o), 128'(0));
    check("rst_wr_pulse", 128'(wr_pulse_o), 128'(0));
    check("rst_wr_index", 128'(wr_index_o), 128'(0));
    rst_i = 1'b0;

    // Table of classic single transfers.
    for (int i = 0; i < 18; i++) classic(vecs[i]);

    // Burst read 0x000E..0x0001 with wrap, one beat per clock.
    exp_q.push_back(8'h0E); exp_q.push_back(8'h0F);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 16'h000E; we_i = 1'b0; cti_i = CTI_INCR;
    wait_ack(got);
    check("br_first_ack", 128'(got), 128'(1));
    if (got) begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk_i);
        check("br_ack", 128'(ack_o), 128'(1));
        check("br_data", 128'(dat_o), 128'(exp_q.pop_front()));
        if (k == 3) cti_i = CTI_END;
      end
    end
    @(posedge clk_i); #1;
    bus_idle();
    @(negedge clk_i);
    check("br_ack_end", 128'(ack_o), 128'(0));
    exp_q.delete();

    // Burst write to 8..11, cyc_i dropped after the second beat.
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 16'h0008; we_i = 1'b1; dat_i = 8'h81;
    sel_i = 1'b1; cti_i = CTI_INCR;
    wait_ack(got);
    check("bw_first_ack", 128'(got), 128'(1));
    if (got) begin
      model[8] = 8'h81;
      @(posedge clk_i); #1;
      dat_i = 8'h82;
      @(negedge clk_i);
      check("bw_beat2_ack", 128'(ack_o), 128'(1));
      model[9] = 8'h82;
      @(posedge clk_i); #1;
      dat_i = 8'h83;
      cyc_i = 1'b0;
      #1;
      check("bw_ack_drop_same_cycle", 128'(ack_o), 128'(0));
      @(negedge clk_i);
      check("bw_wr_index", 128'(wr_index_o), 128'(9));
    end
    bus_idle();
    @(negedge clk_i);
    check("bw_regs", 128'(regs_o), 128'(image()));

    // Asynchronous reset in the middle of a burst read from 0x0004.
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 16'h0004; we_i = 1'b0; cti_i = CTI_INCR;
    wait_ack(got);
    check("rb_first_ack", 128'(got), 128'(1));
    check("rb_data", 128'(dat_o), 128'(8'h77));
    #1 rst_i = 1'b1;
    #1;
    check("rb_rst_ack", 128'(ack_o), 128'(0));
    check("rb_rst_dat", 128'(dat_o), 128'(0));
    check("rb_rst_regs", 128'(regs_o), 128'(0));
    check("rb_rst_wr_pulse", 128'(wr_pulse_o), 128'(0));
    check("rb_rst_wr_index", 128'(wr_index_o), 128'(0));
    bus_idle();
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    @(negedge clk_i);
    rst_i = 1'b0;

    v = '{16'h0003, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 4'h0, 8'h00};
    classic(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/wishbone_slave_regs.md
# wishbone_slave_regs

Wishbone B4 responder exposing a bank of DEPTH data registers at BASE_ADDRESS, the target-side counterpart of the team's `wishbone_master`.
- Supports classic single cycles with programmable wait states, and registered-feedback incrementing bursts (CTI 010/111).
- Mirrors every register to fabric logic, and accepts a fabric-side write port so status registers can be updated by hardware.

## Interface
- ADDRESS_WIDTH, 16, bus address width
- DATA_WIDTH, 8, bus data width
- DATA_BYTES, 1, byte-select lanes (DATA_WIDTH/8)
- BASE_ADDRESS, 16'h0000, first decoded address
- DEPTH, 16, number of registers; power of two, 2..64
- WAIT_STATES, 1, idle cycles before first ack of any transfer, 0..15
- REQUIRE_STB, 0, 1 = transfer qualified by cyc_i&stb_i; 0 = cyc_i alone
- INDEX_N, derived, clog2(DEPTH)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- adr_i  in  ADDRESS_WIDTH  bus address
- dat_i  in  DATA_WIDTH  write data
- dat_o  out  DATA_WIDTH  read data
- we_i  in  1  write enable
- sel_i  in  DATA_BYTES  byte lanes; all-zero treated as all-ones
- stb_i  in  1  strobe
- cyc_i  in  1  cycle valid
- cti_i  in  3  cycle type
- ack_o  out  1  acknowledge
- regs_o  out  DEPTH*DATA_WIDTH  flat register image, reg k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse_o  out  1  one-cycle pulse per bus write beat
- wr_index_o  out  INDEX_N  index of last bus write
- hw_we_i  in  1  fabric write request
- hw_index_i  in  INDEX_N  fabric write index
- hw_data_i  in  DATA_WIDTH  fabric write data

## Operation
- Request = cyc_i & (stb_i | !REQUIRE_STB) & BASE_ADDRESS <= adr_i < BASE_ADDRESS+DEPTH.
- index = adr_i - BASE_ADDRESS, truncated to INDEX_N.
- States:
  - IDLE: on request, latch ptr=index, load wait counter=WAIT_STATES, go WAIT; if WAIT_STATES=0 go ACK directly.
  - WAIT: decrement counter; at 0 go ACK. Out-of-range or dropped request returns to IDLE.
  - ACK: ack_o high one beat. Next state:
    - BURST if cti_i==010 (ptr <= ptr+1, wraps modulo DEPTH);
    - otherwise IDLE (cti 000/111/other).
  - BURST: ack_o high every cycle. Each beat advances ptr (modulo DEPTH); cti_i==111 on an acked beat makes it final, then IDLE.
- Reads: dat_o is a register.
  - Loaded with reg[ptr] on the edge entering ACK/BURST beats, i.e. valid during the ack cycle.
  - During bursts it prefetches reg[ptr+1].
  - Held otherwise; not driven from adr_i combinationally.
- Writes: on each acked beat with we_i, reg[ptr] lanes per sel_i <= dat_i.
  - wr_pulse_o=1 the next cycle; wr_index_o=ptr.
- ack_o = ack_reg & cyc_i: drops in the same cycle cyc_i falls.
- cyc_i low in any state forces IDLE next edge; no write occurs on an unacked beat.
- Out-of-range address: never acked; master timeout handles it.
- hw_we_i writes reg[hw_index_i] <= hw_data_i whenever no bus write to the same index occurs that edge. On collision the bus write wins and the hw write is dropped.
- Reset values: ack_o 0, dat_o 0, regs_o all 0, wr_pulse_o 0, wr_index_o 0, state IDLE, ptr 0.

## Timing
- Request sampled at edge E0.
- First ack_o is high in cycle E0+1+WAIT_STATES (registered).
- Burst beats after the first have zero wait: one beat per clock.
- regs_o reflects a write from the edge after the acked beat.
- Read of a register written by the immediately preceding beat returns the new value; the bypass is required in bursts.
- Minimum one idle (ack low) cycle between classic transfers.

## Structure
- Shared package `wishbone_pkg`:
  - CTI constants CTI_CLASSIC 3'b000, CTI_CONST 3'b001, CTI_INCR 3'b010, CTI_END 3'b111.
  - One-hot state encodings for the responder.
- Sub-module `register_bank`: DEPTH×DATA_WIDTH array with two write ports (bus with sel lanes, priority; fabric), one read port, and the flat regs_o export.
- The top level holds the FSM, wait counter and pointer.

## Test plan
- Classic write, WAIT_STATES=1, adr 0x0003, dat 0xA5, cti 000 → ack_o high exactly cycle E0+2; reg3=0xA5; wr_pulse_o one cycle with wr_index_o=3.
- Classic read of reg3 → dat_o=0xA5 during the ack cycle; ack_o low the next cycle.
- Burst read of 4 beats from 0x000E, regs 14..1 preset (0x0E,0x0F,0x00,0x01) with cti 010,010,010,111 → acks on 4 consecutive cycles returning 0x0E,0x0F,0x00,0x01 (wrap); IDLE after.
- cyc_i dropped after 2nd of 4 burst write beats → only 2 registers changed; ack_o low the same cycle.
- Address 0x0010 with DEPTH=16 → no ack for 20 cycles; regs unchanged.
- Bus write and hw_we_i to the same index on the same edge → bus data kept. Different index → both written.
- rst_i asserted mid-burst → all outputs at reset values immediately, asynchronously.
